// File: rtl/ps2_key_event_queue.sv
// ps2_key_event_queue: merges decoded key events (toggle-strobed) and raw
// PS/2 set-2 scan bytes (E0/F0 prefix parsing) into one FIFO. The FIFO is
// replayed onto the 11-bit ps2_key bus with a minimum spacing between updates.
// Optional feature macro: PS2_KEY_REPEAT_FILTER_EN. When defined, typematic
// repeats of the last accepted make are discarded before the FIFO.
module ps2_key_event_queue #(
  parameter  int DEPTH      = 8,
  parameter  int GAP_CYCLES = 16,
  localparam int LVL_W      = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ev_strobe,
  input  logic [7:0]       ev_code,
  input  logic             ev_ext,
  input  logic             ev_pressed,
  input  logic             raw_valid,
  input  logic [7:0]       raw_byte,
  output logic [10:0]      ps2_key,
  output logic             overflow,
  output logic [LVL_W-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  // Entry layout is {pressed, ext, code}, matching ps2_key[9:0].
  logic [9:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic [GW-1:0]    gap_q;
  logic [10:0]      key_q;
  logic             ovf_q;
  logic             ev_last_q;
  logic             ext_q, brk_q;
  logic             skid_vld_q;
  logic [9:0]       skid_q;

  logic       ev_fire, raw_is_pfx, raw_fire;
  logic [9:0] ev_entry, raw_entry, wr_entry;
  logic       wr_req, skid_drain, filt_hit, push_req, push_ok, pop, full;
  logic       drop_fifo, skid_load, drop_skid;

  assign ev_fire    = (ev_strobe != ev_last_q);
  assign ev_entry   = {ev_pressed, ev_ext, ev_code};
  assign raw_is_pfx = (raw_byte == 8'hE0) || (raw_byte == 8'hF0);
  assign raw_fire   = raw_valid && !raw_is_pfx;
  assign raw_entry  = {~brk_q, ext_q, raw_byte};

  // Event port has priority for the single FIFO write slot; the skid waits.
  assign wr_req     = ev_fire || skid_vld_q;
  assign wr_entry   = ev_fire ? ev_entry : skid_q;
  assign skid_drain = skid_vld_q && !ev_fire;

`ifdef PS2_KEY_REPEAT_FILTER_EN
  logic       rep_vld_q;
  logic [8:0] rep_q;
  // A make identical to the last accepted make (no break since) is a repeat.
  assign filt_hit = wr_entry[9] && rep_vld_q && (wr_entry[8:0] == rep_q);

  // Track the last accepted make; its break re-arms the filter.
  always_ff @(posedge clk) begin
    if (reset) begin
      rep_vld_q <= 1'b0;
      rep_q     <= '0;
    end else if (push_ok) begin
      if (wr_entry[9]) begin
        rep_vld_q <= 1'b1;
        rep_q     <= wr_entry[8:0];
      end else if (wr_entry[8:0] == rep_q) begin
        rep_vld_q <= 1'b0;
      end
    end
  end
`else
  assign filt_hit = 1'b0;
`endif

  assign full      = (level_q == LVL_W'(DEPTH));
  assign pop       = (level_q != '0) && (gap_q == '0);
  assign push_req  = wr_req && !filt_hit;
  // A pop frees the slot in the same edge, so full+pop still accepts a push.
  assign push_ok   = push_req && (!full || pop);
  assign drop_fifo = push_req && full && !pop;
  assign skid_load = raw_fire && (!skid_vld_q || skid_drain);
  assign drop_skid = raw_fire && skid_vld_q && !skid_drain;

  // Raw parser prefix flags and the one-entry skid ahead of the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      skid_vld_q <= 1'b0;
      skid_q     <= '0;
    end else begin
      if (raw_valid) begin
        if (raw_byte == 8'hE0)      ext_q <= 1'b1;
        else if (raw_byte == 8'hF0) brk_q <= 1'b1;
        else begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
        end
      end
      if (skid_load) begin
        skid_vld_q <= 1'b1;
        skid_q     <= raw_entry;
      end else if (skid_drain) begin
        skid_vld_q <= 1'b0;
      end
    end
  end

  // Event strobe edge detect; reset re-syncs to the live strobe level.
  always_ff @(posedge clk) begin
    if (reset) ev_last_q <= ev_strobe;
    else       ev_last_q <= ev_strobe;
  end

  // FIFO storage; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_entry;
  end

  // FIFO pointers, occupancy, sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (drop_fifo || drop_skid) ovf_q <= 1'b1;
    end
  end

  // Replay: pop onto ps2_key, flip the toggle bit, then hold off GAP_CYCLES.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_q <= '0;
      gap_q <= '0;
    end else if (pop) begin
      key_q <= {~key_q[10], mem_q[rd_ptr_q]};
      gap_q <= GW'(GAP_CYCLES);
    end else if (gap_q != '0) begin
      gap_q <= gap_q - 1'b1;
    end
  end

  assign ps2_key  = key_q;
  assign overflow = ovf_q;
  assign level    = level_q;

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Directed bench for ps2_key_event_queue at DEPTH=8, GAP_CYCLES=16.
module tb_ps2_key_event_queue;
  logic        clk = 1'b0, reset = 1'b1;
  logic        ev_strobe = 1'b1, ev_ext = 1'b0, ev_pressed = 1'b0;
  logic [7:0]  ev_code = 8'h00, raw_byte = 8'h00;
  logic        raw_valid = 1'b0;
  logic [10:0] ps2_key;
  logic        overflow;
  logic [3:0]  level;

  int total = 0, bad = 0, cyc = 0, base = 0;
  logic [10:0] upd_key[$];
  int          upd_cyc[$];
  logic        prev10 = 1'b0;

  ps2_key_event_queue #(.DEPTH(8), .GAP_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .ev_strobe(ev_strobe), .ev_code(ev_code),
    .ev_ext(ev_ext), .ev_pressed(ev_pressed), .raw_valid(raw_valid),
    .raw_byte(raw_byte), .ps2_key(ps2_key), .overflow(overflow), .level(level)
  );

  always #5 clk = ~clk;

  // cycle counter, used for update spacing
  always @(posedge clk) cyc <= cyc + 1;

  // log every toggle of ps2_key[10] outside reset
  always @(negedge clk) begin
    if (reset) prev10 <= ps2_key[10];
    else if (ps2_key[10] !== prev10) begin
      prev10 <= ps2_key[10];
      upd_key.push_back(ps2_key);
      upd_cyc.push_back(cyc);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ev(input logic [7:0] code, input logic ext, input logic pr);
    ev_code = code; ev_ext = ext; ev_pressed = pr;
    ev_strobe = ~ev_strobe;
    step();
  endtask

  task automatic raw(input logic [7:0] b);
    raw_valid = 1'b1; raw_byte = b;
    step();
    raw_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    // reset with strobe high, then hold it: no event
    step(2);
    reset = 1'b0;
    chk("rst_key", ps2_key, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", overflow, 0);
    step(4);
    chk("hold_no_upd", upd_key.size(), 0);
    chk("hold_level", level, 0);

    // event port, idle queue: visible one edge after the write
    ev(8'h1C, 1'b0, 1'b1);
    chk("ev_written_level", level, 1);
    chk("ev_not_yet", ps2_key, 0);
    step();
    chk("ev_key", ps2_key, 11'h61C);
    chk("ev_popped_level", level, 0);

    // raw E0 F0 75: one extended break, one extra cycle through skid
    step(20);
    base = upd_key.size();
    raw(8'hE0);
    raw(8'hF0);
    raw(8'h75);
    chk("raw_pfx_no_upd", ps2_key, 11'h61C);
    step();
    chk("raw_skid_cycle", ps2_key, 11'h61C);
    step();
    chk("raw_e0f0_key", ps2_key, 11'h175);
    step(20);
    raw(8'hF0);
    raw(8'hE0);
    raw(8'h6B);
    step(2);
    chk("raw_f0e0_key", ps2_key, 11'h56B);
    step(2);
    chk("raw_upd_count", upd_key.size() - base, 2);

    // 10 back-to-back toggles into DEPTH=8: the 10th is dropped
    step(20);
    base = upd_key.size();
    for (int i = 0; i < 9; i++) ev(8'h10 + 8'(i), 1'b0, 1'b1);
    chk("burst9_level", level, 8);
    chk("burst9_ovf", overflow, 0);
    ev(8'h19, 1'b0, 1'b1);
    chk("burst10_level", level, 8);
    chk("burst10_ovf", overflow, 1);
    step(170);
    chk("burst_upd_count", upd_key.size() - base, 9);
    for (int i = 0; i < 9; i++)
      chk($sformatf("burst_key%0d", i), upd_key[base+i][9:0], 10'h210 + i);
    for (int i = 1; i < 9; i++)
      chk($sformatf("burst_gap%0d", i), upd_cyc[base+i] - upd_cyc[base+i-1], 17);
    chk("burst_drained", level, 0);

    // event port and skid collide: event goes first, raw follows
    do_reset();
    chk("rst2_ovf", overflow, 0);
    base = upd_key.size();
    raw(8'h2A);
    ev(8'h33, 1'b1, 1'b0);
    step(40);
    chk("coll_count", upd_key.size() - base, 2);
    chk("coll_first", upd_key[base], 11'h533);
    chk("coll_second", upd_key[base+1], 11'h22A);
    chk("coll_ovf", overflow, 0);

    // make x3, break, make
    do_reset();
    base = upd_key.size();
    ev(8'h1C, 1'b0, 1'b1);
    ev(8'h1C, 1'b0, 1'b1);
    ev(8'h1C, 1'b0, 1'b1);
    ev(8'h1C, 1'b0, 1'b0);
    ev(8'h1C, 1'b0, 1'b1);
    step(120);
`ifdef PS2_KEY_REPEAT_FILTER_EN
    chk("rep_count", upd_key.size() - base, 3);
`else
    chk("rep_count", upd_key.size() - base, 5);
`endif
    chk("rep_last", ps2_key[9:0], 10'h21C);
    chk("rep_ovf", overflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
